// File: rtl/apb_controller.sv
// apb_controller: AHB-to-APB bridge FSM that produces a registered APB master interface from a pipelined AHB slave stage
// Ports: Hclk, Hreset (synchronous, active-high); AHB side valid, Hwrite, Hwritereg, Haddr/Haddr1/Haddr2,
//   Hwdata/Hwdata1, tempselx; Pready (present only when APB_PREADY_EN is defined); APB side Pwrite, Penable,
//   Pselx, Paddr, Pwdata; Hreadyout returned to the AHB master.
// Optional macro APB_PREADY_EN: enable states stall on Pready=0 and drive Hreadyout low while in them.
module apb_controller (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        valid,
  input  logic        Hwrite,
  input  logic        Hwritereg,
  input  logic [31:0] Haddr,
  input  logic [31:0] Haddr1,
  input  logic [31:0] Haddr2,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Hwdata1,
  input  logic [2:0]  tempselx,
`ifdef APB_PREADY_EN
  input  logic        Pready,
`endif
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout
);
  typedef enum logic [2:0] {IDLE, WWAIT, READ, RENABLE, WRITE, WRITEP, WENABLE, WENABLEP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  sel1_q, sel2_q, pselx_q, pselx_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d, penable_q, penable_d, hready_q, hready_d;
  logic        ack, from_p;
`ifdef APB_PREADY_EN
  localparam logic EN_RDY = 1'b0;
  assign ack = Pready;
`else
  localparam logic EN_RDY = 1'b1;
  assign ack = 1'b1;
`endif
  // A transfer entered from WENABLEP was captured one cycle earlier, so it reads the older pipeline taps.
  assign from_p = state_q == WENABLEP;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             state_d = !valid ? IDLE : Hwrite ? WWAIT : READ;
      WWAIT:            state_d = valid ? WRITEP : WRITE;
      READ:             state_d = RENABLE;
      WRITEP:           state_d = WENABLEP;
      WRITE:            state_d = valid ? WENABLEP : WENABLE;
      RENABLE, WENABLE: state_d = !ack ? state_q : !valid ? IDLE : Hwrite ? WWAIT : READ;
      WENABLEP:         state_d = !ack ? state_q : !Hwritereg ? READ : valid ? WRITEP : WRITE;
      default:          state_d = IDLE;
    endcase
  end
  // Outputs are computed for the state being entered so they change on the same edge as the state.
  always_comb begin
    pselx_d   = pselx_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    hready_d  = hready_q;
    case (state_d)
      IDLE, WWAIT: begin
        pselx_d   = 3'b000;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
      READ: begin
        paddr_d   = from_p ? Haddr1 : Haddr;
        pselx_d   = from_p ? sel1_q : tempselx;
        pwrite_d  = 1'b0;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      WRITE, WRITEP: begin
        paddr_d   = from_p ? Haddr2 : Haddr1;
        pwdata_d  = from_p ? Hwdata1 : Hwdata;
        pselx_d   = from_p ? sel2_q : sel1_q;
        pwrite_d  = 1'b1;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      default: begin
        penable_d = 1'b1;
        hready_d  = EN_RDY;
      end
    endcase
  end
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= IDLE;
      sel1_q    <= 3'b000;
      sel2_q    <= 3'b000;
      pselx_q   <= 3'b000;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel1_q    <= tempselx;
      sel2_q    <= sel1_q;
      pselx_q   <= pselx_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      hready_q  <= hready_d;
    end
  end
  assign Pselx     = pselx_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Pwrite    = pwrite_q;
  assign Penable   = penable_q;
  assign Hreadyout = hready_q;
endmodule

// File: tb/tb_apb_controller.sv
// tb_apb_controller: table-driven scoreboard bench for apb_controller
module tb_apb_controller;
  logic        Hclk = 1'b0, Hreset = 1'b1, valid = 1'b0, Hwrite = 1'b0, Hwritereg = 1'b0, pready = 1'b1;
  logic [31:0] Haddr = '0, Haddr1 = '0, Haddr2 = '0, Hwdata = '0, Hwdata1 = '0;
  logic [2:0]  tempselx;
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata;

  typedef struct packed {
    logic [2:0]  psel;
    logic        pen, pwr, rdy;
    logic [31:0] paddr, pwdata;
  } out_t;
  typedef struct packed {
    logic        rst, vld, wr, prdy;
    logic [31:0] addr, wdata;
    out_t        exp;
  } vec_t;

  apb_controller dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite), .Hwritereg(Hwritereg),
    .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata(Hwdata), .Hwdata1(Hwdata1),
    .tempselx(tempselx),
`ifdef APB_PREADY_EN
    .Pready(pready),
`endif
    .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata),
    .Hreadyout(Hreadyout)
  );

  always #5 Hclk = ~Hclk;

  // AHB slave-stage pipeline feeding the delayed ports
  always @(posedge Hclk) begin
    Haddr1    <= Haddr;
    Haddr2    <= Haddr1;
    Hwdata1   <= Hwdata;
    Hwritereg <= Hwrite;
  end

  always_comb
    tempselx = Haddr[31:26] == 6'b100000 ? 3'b001 :
               Haddr[31:26] == 6'b100001 ? 3'b010 :
               Haddr[31:26] == 6'b100010 ? 3'b100 : 3'b000;

  int   n_vec = 0, n_bad = 0;
  out_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] s, input logic pe, input logic pw,
                              input logic rd, input logic [31:0] pa, input logic [31:0] pd);
    vec_t t;
    t.rst = r; t.vld = v; t.wr = w; t.prdy = 1'b1; t.addr = a; t.wdata = d;
    t.exp.psel = s; t.exp.pen = pe; t.exp.pwr = pw; t.exp.rdy = rd; t.exp.paddr = pa; t.exp.pwdata = pd;
    return t;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    out_t e, a;
    @(negedge Hclk);
    Hreset = v.rst; valid = v.vld; Hwrite = v.wr; pready = v.prdy; Haddr = v.addr; Hwdata = v.wdata;
    e = v.exp;
`ifdef APB_PREADY_EN
    if (e.pen) e.rdy = 1'b0;
`endif
    sb.push_back(e);
    @(posedge Hclk);
    #1;
    a = {Pselx, Penable, Pwrite, Hreadyout, Paddr, Pwdata};
    e = sb.pop_front();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got psel=%b pen=%b pwr=%b rdy=%b paddr=%h pwdata=%h, want psel=%b pen=%b pwr=%b rdy=%b paddr=%h pwdata=%h",
               nm, a.psel, a.pen, a.pwr, a.rdy, a.paddr, a.pwdata, e.psel, e.pen, e.pwr, e.rdy, e.paddr, e.pwdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t t;
    bit   ok;
    //               rst v  w  haddr         hwdata        psel    pe  pw  rd  paddr         pwdata
    tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        3'b000, 0, 0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        3'b000, 0, 0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h80000010, 32'h0,        3'b001, 0, 0, 0, 32'h80000010, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h80000010, 32'h0,        3'b001, 1, 0, 1, 32'h80000010, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h80000010, 32'h0,        3'b000, 0, 0, 1, 32'h80000010, 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h84000020, 32'h0,        3'b000, 0, 0, 1, 32'h80000010, 32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h84000020, 32'hDEADBEEF, 3'b010, 0, 1, 0, 32'h84000020, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 1, 32'h84000020, 32'hDEADBEEF, 3'b010, 1, 1, 1, 32'h84000020, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 1, 32'h84000020, 32'hDEADBEEF, 3'b000, 0, 1, 1, 32'h84000020, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 1, 32'h88000000, 32'hDEADBEEF, 3'b000, 0, 1, 1, 32'h84000020, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 1, 32'h88000004, 32'h1,        3'b100, 0, 1, 0, 32'h88000000, 32'h1));
    tbl.push_back(mk(0, 0, 1, 32'h88000004, 32'h2,        3'b100, 1, 1, 1, 32'h88000000, 32'h1));
    tbl.push_back(mk(0, 0, 1, 32'h88000004, 32'h2,        3'b100, 0, 1, 0, 32'h88000004, 32'h2));
    tbl.push_back(mk(0, 0, 1, 32'h88000004, 32'h2,        3'b100, 1, 1, 1, 32'h88000004, 32'h2));
    tbl.push_back(mk(0, 0, 1, 32'h88000004, 32'h2,        3'b000, 0, 1, 1, 32'h88000004, 32'h2));
    tbl.push_back(mk(0, 1, 1, 32'h84000040, 32'h2,        3'b000, 0, 1, 1, 32'h88000004, 32'h2));
    tbl.push_back(mk(0, 1, 0, 32'h80000008, 32'hCAFEF00D, 3'b010, 0, 1, 0, 32'h84000040, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 0, 32'h80000008, 32'hCAFEF00D, 3'b010, 1, 1, 1, 32'h84000040, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 0, 32'h80000008, 32'hCAFEF00D, 3'b001, 0, 0, 0, 32'h80000008, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 0, 32'h80000008, 32'hCAFEF00D, 3'b001, 1, 0, 1, 32'h80000008, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 0, 32'h80000008, 32'hCAFEF00D, 3'b000, 0, 0, 1, 32'h80000008, 32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 0, 32'h84000100, 32'hCAFEF00D, 3'b010, 0, 0, 0, 32'h84000100, 32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 0, 32'h88000200, 32'hCAFEF00D, 3'b010, 1, 0, 1, 32'h84000100, 32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 0, 32'h88000200, 32'hCAFEF00D, 3'b100, 0, 0, 0, 32'h88000200, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 0, 32'h88000200, 32'hCAFEF00D, 3'b100, 1, 0, 1, 32'h88000200, 32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 1, 32'h84000300, 32'hCAFEF00D, 3'b000, 0, 0, 1, 32'h88000200, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 1, 32'h84000300, 32'h12345678, 3'b010, 0, 1, 0, 32'h84000300, 32'h12345678));
    tbl.push_back(mk(0, 0, 1, 32'h84000300, 32'h12345678, 3'b010, 1, 1, 1, 32'h84000300, 32'h12345678));
    tbl.push_back(mk(0, 1, 1, 32'h88000010, 32'h12345678, 3'b000, 0, 1, 1, 32'h84000300, 32'h12345678));
    tbl.push_back(mk(0, 1, 1, 32'h88000014, 32'hAAAA5555, 3'b100, 0, 1, 0, 32'h88000010, 32'hAAAA5555));
    tbl.push_back(mk(0, 0, 1, 32'h88000014, 32'h5555AAAA, 3'b100, 1, 1, 1, 32'h88000010, 32'hAAAA5555));
    tbl.push_back(mk(1, 0, 1, 32'h88000014, 32'h5555AAAA, 3'b000, 0, 0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h88000014, 32'h5555AAAA, 3'b000, 0, 0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h80000020, 32'h0,        3'b001, 0, 0, 0, 32'h80000020, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h80000020, 32'h0,        3'b000, 0, 0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h80000020, 32'h0,        3'b000, 0, 0, 1, 32'h0,        32'h0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // read completes, bus idles, then a later transfer is still taken exactly once
    apply(mk(0, 1, 0, 32'h84000008, 32'h0, 3'b010, 0, 0, 0, 32'h84000008, 32'h0), "late_rd");
    apply(mk(0, 0, 0, 32'h84000008, 32'h0, 3'b010, 1, 0, 1, 32'h84000008, 32'h0), "late_ren");
    apply(mk(0, 0, 0, 32'h84000008, 32'h0, 3'b000, 0, 0, 1, 32'h84000008, 32'h0), "late_idle0");
    apply(mk(0, 0, 0, 32'h84000008, 32'h0, 3'b000, 0, 0, 1, 32'h84000008, 32'h0), "late_idle1");
    apply(mk(0, 1, 0, 32'h88000008, 32'h0, 3'b100, 0, 0, 0, 32'h88000008, 32'h0), "late_rd2");
    apply(mk(0, 0, 0, 32'h88000008, 32'h0, 3'b100, 1, 0, 1, 32'h88000008, 32'h0), "late_ren2");
    apply(mk(0, 0, 0, 32'h88000008, 32'h0, 3'b000, 0, 0, 1, 32'h88000008, 32'h0), "late_idle2");

`ifdef APB_PREADY_EN
    // Pready low for three RENABLE cycles stalls the enable phase
    apply(mk(0, 1, 0, 32'h80000010, 32'h0, 3'b001, 0, 0, 0, 32'h80000010, 32'h0), "rdy_read");
    t = mk(0, 0, 0, 32'h80000010, 32'h0, 3'b001, 1, 0, 0, 32'h80000010, 32'h0);
    t.prdy = 1'b0;
    apply(t, "rdy_enter");
    for (int i = 0; i < 3; i++) apply(t, $sformatf("rdy_hold%0d", i));
    apply(mk(0, 0, 0, 32'h80000010, 32'h0, 3'b000, 0, 0, 1, 32'h80000010, 32'h0), "rdy_exit");
`endif

    // random traffic: one-hot select, no enable without select, ready consistent with phase
    for (int i = 0; i < 150; i++) begin
      @(negedge Hclk);
      Hreset = 1'b0;
      pready = 1'b1;
      valid  = 1'($urandom_range(0, 1));
      Hwrite = 1'($urandom_range(0, 1));
      Haddr  = {4'h8, 2'($urandom_range(0, 2)), 2'b00, 24'($urandom)};
      Hwdata = $urandom;
      @(posedge Hclk);
      #1;
`ifdef APB_PREADY_EN
      ok = $onehot0(Pselx) && (!Penable || Pselx != 3'b000) && (Hreadyout == (Pselx == 3'b000));
`else
      ok = $onehot0(Pselx) && (!Penable || Pselx != 3'b000) && (Hreadyout == (Penable || Pselx == 3'b000));
`endif
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL inv%0d: got psel=%b pen=%b rdy=%b, want one-hot/zero psel, pen only with psel, rdy matching phase",
                 i, Pselx, Penable, Hreadyout);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
